// File: rtl/bist_pkg.sv
// bist_pkg: shared FSM states, MISR constants and zero-seed substitute for the BIST pattern generator
package bist_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    localparam logic [15:0] MISR_TAPS = 16'h8810;
    localparam logic [15:0] MISR_RST = 16'hFFFF;
    localparam int ZERO_SEED_SUB = 1;
endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr: Fibonacci shift register with parallel load and XOR injection (LFSR or MISR)
module bist_lfsr #(
    parameter int WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS = 5'b10100,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             advance,
    input  logic [WIDTH-1:0] inject,
    output logic [WIDTH-1:0] state
);
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;
    assign w_next = {r_state[WIDTH-2:0], ^(r_state & TAPS)};
    assign state = r_state;
    // load wins over advance; an advancing step folds in the injected word
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= RST_VAL;
        else if (load) r_state <= seed;
        else if (advance) r_state <= w_next ^ inject;
    end
endmodule

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: LFSR stimulus generator with IDLE/RUN/DONE control; optional MISR via BIST_MISR_EN
module bist_pattern_gen
    import bist_pkg::*;
#(
    parameter int VEC_WIDTH = 5,
    parameter int VEC_LENGTH = 32,
    parameter logic [VEC_WIDTH-1:0] TAPS = 5'b10100,
    parameter int RESP_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VEC_WIDTH-1:0]  seed_in,
`ifdef BIST_MISR_EN
    input  logic [RESP_WIDTH-1:0] resp_in,
    output logic [15:0]           signature,
`endif
    output logic [VEC_WIDTH-1:0]  vec_out,
    output logic                  vec_valid,
    output logic [15:0]           vec_idx,
    output logic                  busy,
    output logic                  done
);
    state_t r_state;
    logic r_valid, r_busy, r_done;
    logic [15:0] r_idx;
    logic w_accept, w_last, w_advance;
    logic [VEC_WIDTH-1:0] w_seed;
    assign w_accept = (r_state != ST_RUN) && start;
    assign w_last = r_idx == 16'(VEC_LENGTH - 1);
    assign w_advance = (r_state == ST_RUN) && !w_last;
    assign w_seed = (seed_in == '0) ? VEC_WIDTH'(ZERO_SEED_SUB) : seed_in;
    assign vec_valid = r_valid;
    assign vec_idx = r_idx;
    assign busy = r_busy;
    assign done = r_done;
    // the LFSR register itself drives vec_out; it stops on the last vector so the value holds in DONE
    bist_lfsr #(.WIDTH(VEC_WIDTH), .TAPS(TAPS), .RST_VAL('0)) u_lfsr (
        .clk(clk), .rst_n(rst_n), .load(w_accept), .seed(w_seed),
        .advance(w_advance), .inject('0), .state(vec_out)
    );
`ifdef BIST_MISR_EN
    // each valid cycle's response is folded in at the closing edge, so the last one lands as done rises
    bist_lfsr #(.WIDTH(16), .TAPS(MISR_TAPS), .RST_VAL(MISR_RST)) u_misr (
        .clk(clk), .rst_n(rst_n), .load(w_accept), .seed(MISR_RST),
        .advance(r_valid), .inject(16'(resp_in)), .state(signature)
    );
`endif
    // control FSM with registered status outputs; start is only honoured outside RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_idx <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_last) begin
                r_state <= ST_DONE;
                r_valid <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_idx <= r_idx + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_bist_pattern_gen.sv
// tb_bist_pattern_gen: directed checks of the BIST pattern generator (MISR checks with BIST_MISR_EN)
module tb_bist_pattern_gen;
    logic clk = 1'b0;
    logic rst_n, start;
    logic [4:0] seed_in, vec_out;
    logic [1:0] resp_in;
    logic [15:0] signature, vec_idx;
    logic vec_valid, busy, done;
    int n_tests = 0;
    int n_fail = 0;
    logic [4:0] tab [0:5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
    logic [15:0] sig_clean;

    bist_pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in),
`ifdef BIST_MISR_EN
        .resp_in(resp_in), .signature(signature),
`endif
        .vec_out(vec_out), .vec_valid(vec_valid), .vec_idx(vec_idx),
        .busy(busy), .done(done)
    );

`ifndef BIST_MISR_EN
    assign signature = 16'hFFFF;
`endif

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] lfsr_next(input logic [4:0] v);
        return {v[3:0], v[4] ^ v[2]};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [1:0] r);
        return {s[14:0], s[15] ^ s[11] ^ s[4]} ^ {14'd0, r};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vec"}, vec_out, 0);
        check({tag, "_valid"}, vec_valid, 0);
        check({tag, "_idx"}, vec_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
`ifdef BIST_MISR_EN
        check({tag, "_sig"}, signature, 16'hFFFF);
`endif
    endtask

    task automatic do_run(input logic [4:0] seed, input logic hold, input logic use_tab,
                          input logic flip, output logic [15:0] sig_out);
        logic [4:0] ev, first, last_vec;
        logic [15:0] g, last_idx;
        logic [1:0] r;
        int cnt;
        seed_in = seed;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        ev = (seed == 5'd0) ? 5'd1 : seed;
        first = ev;
        g = 16'hFFFF;
        check("first_vec", vec_out, ev);
        check("first_busy", busy, 1);
        check("first_done", done, 0);
        check("first_valid", vec_valid, 1);
`ifdef BIST_MISR_EN
        check("sig_cleared", signature, 16'hFFFF);
`endif
        cnt = 0;
        last_vec = '0;
        last_idx = '0;
        while (busy === 1'b1 && cnt < 100) begin
            check("vec", vec_out, ev);
            check("idx", vec_idx, cnt);
            if (use_tab && cnt < 6) check("seq_tab", vec_out, tab[cnt]);
            r = (flip && cnt == 7) ? 2'b01 : 2'b00;
            resp_in = r;
            g = misr_next(g, r);
            if (hold && cnt == 31) start = 1'b0;
            last_vec = vec_out;
            last_idx = vec_idx;
            ev = lfsr_next(ev);
            cnt++;
            step();
        end
        resp_in = 2'b00;
        check("run_len", cnt, 32);
        check("last_idx", last_idx, 31);
        check("wrap", last_vec, first);
        check("done_set", done, 1);
        check("valid_low", vec_valid, 0);
        check("vec_hold", vec_out, last_vec);
        check("idx_hold", vec_idx, 31);
`ifdef BIST_MISR_EN
        check("sig_final", signature, g);
`endif
        sig_out = signature;
    endtask

    initial begin
        logic [15:0] s;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        seed_in = '0;
        resp_in = '0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check("idle_busy", busy, 0);
        do_run(5'b00001, 1'b0, 1'b1, 1'b0, sig_clean);
        for (int i = 0; i < 5; i++) step();
        check("done_hold", done, 1);
        check("done_vec_hold", vec_out, 5'b00001);
        do_run(5'b00000, 1'b0, 1'b1, 1'b0, s);
        do_run(5'b00001, 1'b1, 1'b1, 1'b0, s);
        do_run(5'b01001, 1'b0, 1'b0, 1'b0, s);
        seed_in = 5'b00001;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (vec_idx != 16'd10 && n < 50) begin
            step();
            n++;
        end
        check("reach_idx10", vec_idx, 10);
        rst_n = 1'b0;
        step();
        check_reset_outputs("midrun_rst");
        rst_n = 1'b1;
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        do_run(5'b00001, 1'b0, 1'b1, 1'b0, s);
`ifdef BIST_MISR_EN
        check("sig_replay", s, sig_clean);
        do_run(5'b00001, 1'b0, 1'b1, 1'b1, s);
        check("sig_flip_differs", s != sig_clean, 1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bist_pattern_gen.md
BIST_PATTERN_GEN -- requirements
Module: bist_pattern_gen

Interface
REQ-001 The block SHALL have parameter VEC_WIDTH, default 5, giving the width of the stimulus vector driven to the circuit under test.
REQ-002 The block SHALL have parameter VEC_LENGTH, default 32, giving the number of vectors per run (legal range 1..65535).
REQ-003 The block SHALL have parameter TAPS, default 5'b10100, giving the LFSR feedback mask (x^5+x^3+1).
REQ-004 The block SHALL have parameter RESP_WIDTH, default 2, giving the width of the circuit-under-test response.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  run request, sampled in IDLE and DONE.
REQ-008 seed_in  input  VEC_WIDTH  LFSR seed, captured when start is accepted.
REQ-009 vec_out  output  VEC_WIDTH  registered stimulus vector to the circuit under test.
REQ-010 vec_valid  output  1  high in every cycle where vec_out carries a run vector.
REQ-011 vec_idx  output  16  zero-based index of the vector currently on vec_out.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  high in DONE.
REQ-014 resp_in  input  RESP_WIDTH  circuit-under-test response; present only with BIST_MISR_EN.
REQ-015 signature  output  16  MISR signature; present only with BIST_MISR_EN.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE->RUN on start=1:
- LFSR loaded with seed_in, or with 1 if seed_in is all-zero.
- vec_idx cleared.
REQ-018 In RUN, each cycle SHALL:
- drive vec_out = current LFSR state and vec_valid=1;
- advance LFSR to {lfsr[VEC_WIDTH-2:0], ^(lfsr & TAPS)};
- increment vec_idx.
REQ-019 The first vector SHALL appear on vec_out in the cycle after start is sampled (latency 1).
REQ-020 RUN->DONE after exactly VEC_LENGTH valid cycles; vec_valid SHALL be low from the next cycle; vec_out and vec_idx SHALL hold their last values.
REQ-021 VEC_LENGTH greater than the LFSR period SHALL wrap the sequence (the vector at index 31 equals the vector at index 0 for width 5); no error is flagged.
REQ-022 start is ignored in RUN.
REQ-023 start in DONE SHALL restart exactly as from IDLE, with done deasserting in the same cycle RUN is entered.
REQ-024 DONE with start=0 SHALL hold indefinitely.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force state IDLE, vec_out=0, vec_valid=0, vec_idx=0, busy=0, done=0 and signature=16'hFFFF, including mid-run; no partial result is retained.

Configuration
REQ-026 Macro BIST_MISR_EN defined:
- resp_in is compressed into a 16-bit MISR (polynomial x^16+x^12+x^5+1) in the cycle after each vec_valid cycle;
- sig_next = shift(sig) XOR zero-extended resp_in;
- the MISR is cleared to 16'hFFFF when start is accepted;
- signature is final when done rises, after exactly VEC_LENGTH compressions.
REQ-027 Macro BIST_MISR_EN undefined:
- resp_in and signature are absent;
- no MISR logic exists;
- all other behaviour is identical.

Structure
REQ-028 A shared package bist_pkg SHALL hold the FSM state enum, the MISR polynomial and reset constants, and the all-zero seed substitute.
REQ-029 The LFSR SHALL be a sub-module bist_lfsr (parameters WIDTH and TAPS; ports load, seed, advance, state), reused for the MISR shift.

Verification
REQ-030 The bench SHALL cover a basic run: seed 5'b00001, start pulse -> vec_out 00001, 00010, 00100, 01001, 10010, 00101 at vec_idx 0..5; busy high for 32 cycles; then done=1.
REQ-031 The bench SHALL cover the zero-seed guard: seed 5'b00000 -> first vector 00001, with a sequence identical to REQ-030.
REQ-032 The bench SHALL cover wrap-around: VEC_LENGTH=32, seed 5'b00001 -> vector at vec_idx 31 = 00001; done asserts the cycle after vec_idx 31.
REQ-033 The bench SHALL cover reset mid-run: rst_n low at vec_idx 10 -> next cycle IDLE with all outputs at reset values; a new start replays from the seed.
REQ-034 The bench SHALL cover start handling: start held high through RUN -> run length still 32; start in DONE -> restart with first vector = seed.
REQ-035 The bench SHALL cover BIST_MISR_EN: resp_in tied to 2'b00 -> signature equals a golden model of 32 shifts from 16'hFFFF; flipping one response bit at index 7 changes the final signature.
